inv_mixcolumns_iter: RTL



---
 rtl/aes_dec_pkg.sv | 50 +++++
 rtl/inv_mixcolumn.sv | 39 +++
 rtl/inv_mixcolumns_iter.sv | 119 +++++++++++
 3 files changed

// File: rtl/aes_dec_pkg.sv
// Shared AES decryption types, FSM encoding and GF(2^8) helpers.
// Used by inv_mixcolumns_iter and its column engine.
package aes_dec_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_e;

  localparam byte_t GF_POLY = 8'h1B;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY : 8'h00);
  endfunction

  // Inverse coefficients composed from the x2/x4/x8 xtime chain.
  function automatic byte_t gmul9(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic byte_t gmul11(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic byte_t gmul13(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic byte_t gmul14(input byte_t b);
    byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/inv_mixcolumn.sv
// Combinational single-column InvMixColumns engine (row 0 = MSB byte).
// INV_MC_FWD_EN adds fwd_i selecting the forward MixColumns matrix.
module inv_mixcolumn
  import aes_dec_pkg::*;
(
`ifdef INV_MC_FWD_EN
  input  logic fwd_i,
`endif
  input  col_t col_i,
  output col_t col_o
);

  byte_t a0, a1, a2, a3;
  col_t  inv_col;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign inv_col = {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                    gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                    gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                    gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};

`ifdef INV_MC_FWD_EN
  col_t fwd_col;

  assign fwd_col = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                    a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                    a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                    xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};

  assign col_o = fwd_i ? fwd_col : inv_col;
`else
  assign col_o = inv_col;
`endif

endmodule

// File: rtl/inv_mixcolumns_iter.sv
// Iterative InvMixColumns: one column per cycle through a shared engine.
// Optional INV_MC_FWD_EN adds a fwd input selecting forward MixColumns.
module inv_mixcolumns_iter
  import aes_dec_pkg::*;
#(
  parameter int unsigned NCOLS = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
`ifdef INV_MC_FWD_EN
  input  logic         fwd,
`endif
  output logic         busy
);

  if (NCOLS != 4) begin : g_bad_ncols
    $error("inv_mixcolumns_iter: NCOLS must be 4");
  end

  fsm_e        state_q, state_d;
  logic [1:0]  col_q, col_d;
  logic        last_q, last_d;
  state_t      work_q, work_d;
  state_t      out_q, out_d;
  col_t        cur_col, mixed_col;
`ifdef INV_MC_FWD_EN
  logic        fwd_q, fwd_d;
`endif

  inv_mixcolumn u_col (
`ifdef INV_MC_FWD_EN
    .fwd_i (fwd_q),
`endif
    .col_i (cur_col),
    .col_o (mixed_col)
  );

  // last_q marks that column 3 has been written; the following BUSY cycle
  // copies the finished work register into the output register.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    last_d  = last_q;
    work_d  = work_q;
    out_d   = out_q;
`ifdef INV_MC_FWD_EN
    fwd_d   = fwd_q;
`endif
    cur_col = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (col_q == 2'(i)) cur_col = work_q[127 - 32*i -: 32];
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          col_d   = '0;
          last_d  = 1'b0;
`ifdef INV_MC_FWD_EN
          fwd_d   = fwd;
`endif
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (last_q) begin
          out_d   = work_q;
          last_d  = 1'b0;
          state_d = DONE;
        end else begin
          for (int unsigned i = 0; i < 4; i++) begin
            if (col_q == 2'(i)) work_d[127 - 32*i -: 32] = mixed_col;
          end
          col_d = col_q + 2'd1;
          if (col_q == 2'd3) last_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      col_q   <= '0;
      last_q  <= 1'b0;
      work_q  <= '0;
      out_q   <= '0;
`ifdef INV_MC_FWD_EN
      fwd_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      last_q  <= last_d;
      work_q  <= work_d;
      out_q   <= out_d;
`ifdef INV_MC_FWD_EN
      fwd_q   <= fwd_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == BUSY);
  assign out_state = out_q;

endmodule
